// File: rtl/frame_table_server.sv
`default_nettype none
// ============================================================================
// Module      : frame_table_server
// Description : Table-driven telemetry frame source. Streams MARK, payload
//               bytes and a running CRC8 over a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_table_server #(
    parameter int         NUM_FRAMES = 32,
    parameter int         DATA_BYTES = 12,
    parameter int         IDX_W      = $clog2(NUM_FRAMES),
    parameter int         BYTE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1,
    parameter logic [7:0] MARK_BYTE  = 8'hCC,
    parameter logic [7:0] CRC_POLY   = 8'h07,
    parameter logic [7:0] CRC_INIT   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iRQ,
    input  logic [IDX_W-1:0]  iNumRQ,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_frame,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic [7:0]        wr_data,
    output logic [7:0]        oData,
    output logic              oValid,
    input  logic              iReady,
    output logic              oLast,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_MARK     = 3'd1;
    localparam logic [2:0] c_ST_DATA     = 3'd2;
    localparam logic [2:0] c_ST_CRC      = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;
    localparam logic [2:0] c_ST_WAIT_REL = 3'd5;

    localparam logic [31:0]       c_NF       = 32'(NUM_FRAMES);
    localparam logic [31:0]       c_DB       = 32'(DATA_BYTES);
    localparam logic [BYTE_W-1:0] c_LAST_IDX = BYTE_W'(DATA_BYTES - 1);

    logic [2:0]        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_frame, w_frame_nxt;
    logic [BYTE_W-1:0] r_idx, w_idx_nxt;
    logic [7:0]        r_crc, w_crc_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_valid_nxt, w_last_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic              w_xfer, w_wr_ok;
    logic [BYTE_W-1:0] w_rd_byte;
    logic [7:0]        w_rd_data;

    // Storage holds the delta from the (f+b) pattern, so all-zero power-up
    // state reads back as the default content without any reset.
    logic [7:0] r_mem [NUM_FRAMES][DATA_BYTES];

    function automatic logic [7:0] f_dflt(input logic [IDX_W-1:0] f, input logic [BYTE_W-1:0] b);
        return 8'(f) + 8'(b);
    endfunction

    function automatic logic [7:0] f_crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v;
        v = c ^ d;
        for (int i = 0; i < 8; i++) begin
            v = v[7] ? ((v << 1) ^ CRC_POLY) : (v << 1);
        end
        return v;
    endfunction

    assign w_wr_ok = (32'(wr_frame) < c_NF) && (32'(wr_byte) < c_DB);

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[wr_frame][wr_byte] <= wr_data ^ f_dflt(wr_frame, wr_byte);
        end
    end

    // Next byte to load: byte 0 from MARK, otherwise the one after r_idx
    assign w_rd_byte = (r_state == c_ST_DATA && r_idx != c_LAST_IDX) ? r_idx + 1'b1 : '0;
    assign w_rd_data = r_mem[r_frame][w_rd_byte] ^ f_dflt(r_frame, w_rd_byte);
    assign w_xfer    = oValid & iReady;

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_idx_nxt   = r_idx;
        w_crc_nxt   = r_crc;
        w_data_nxt  = oData;
        w_valid_nxt = oValid;
        w_last_nxt  = oLast;
        w_busy_nxt  = oBusy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!iRQ) begin
                    if (32'(iNumRQ) < c_NF) begin
                        w_frame_nxt = iNumRQ;
                        w_idx_nxt   = '0;
                        w_crc_nxt   = CRC_INIT;
                        w_data_nxt  = MARK_BYTE;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = c_ST_MARK;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_ST_WAIT_REL;
                    end
                end
            end
            c_ST_MARK: begin
                if (w_xfer) begin
                    w_data_nxt  = w_rd_data;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_xfer) begin
                    // CRC is folded from the byte actually on the bus
                    w_crc_nxt = f_crc8(r_crc, oData);
                    if (r_idx == c_LAST_IDX) begin
                        w_data_nxt  = f_crc8(r_crc, oData);
                        w_last_nxt  = 1'b1;
                        w_state_nxt = c_ST_CRC;
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_data_nxt = w_rd_data;
                    end
                end
            end
            c_ST_CRC: begin
                if (w_xfer) begin
                    w_data_nxt  = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_WAIT_REL;
            end
            c_ST_WAIT_REL: begin
                if (iRQ) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_WAIT_REL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_WAIT_REL;
            r_frame <= '0;
            r_idx   <= '0;
            r_crc   <= CRC_INIT;
            oData   <= 8'h00;
            oValid  <= 1'b0;
            oLast   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_idx   <= w_idx_nxt;
            r_crc   <= w_crc_nxt;
            oData   <= w_data_nxt;
            oValid  <= w_valid_nxt;
            oLast   <= w_last_nxt;
            oBusy   <= w_busy_nxt;
            oDone   <= w_done_nxt;
            oErr    <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_table_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_table_server
// Description : Self-checking bench for frame_table_server (20 frames x 9 B).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_table_server;

    localparam int NF = 20;
    localparam int DB = 9;
    localparam int IW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          iRQ = 1'b1;
    logic [IW-1:0] iNumRQ = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_frame = '0;
    logic [BW-1:0] wr_byte = '0;
    logic [7:0]    wr_data = '0;
    logic          iReady = 1'b1;
    logic [7:0]    oData;
    logic          oValid, oLast, oBusy, oDone, oErr;

    int total = 0;
    int bad   = 0;

    frame_table_server #(
        .NUM_FRAMES(NF), .DATA_BYTES(DB), .IDX_W(IW), .BYTE_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .iRQ(iRQ), .iNumRQ(iNumRQ),
        .wr_en(wr_en), .wr_frame(wr_frame), .wr_byte(wr_byte), .wr_data(wr_data),
        .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference CRC8 (poly 0x07, init 0), fed one bit at a time MSB first
    function automatic logic [7:0] ref_crc(input logic [7:0] b [DB]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < DB; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ b[i][k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Model: table image, request arming, frame position
    logic [7:0] m_tab [NF][DB];
    logic [7:0] m_sent [DB];
    logic [7:0] got [$];
    bit         m_armed = 1'b0;
    bit         m_in_frame = 1'b0;
    int         m_pos = 0;
    int         m_frame = 0;
    logic       e_valid = 1'b0, e_last = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(negedge clk) begin
        bit was_done;
        chk("valid", 32'(oValid), 32'(e_valid));
        chk("busy", 32'(oBusy), 32'(e_valid));
        chk("done", 32'(oDone), 32'(e_done));
        chk("err", 32'(oErr), 32'(e_err));
        chk("last", 32'(oLast), 32'(e_valid & e_last));
        if (e_valid) chk("data", 32'(oData), 32'(e_data));
        was_done = e_done;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (reset) begin
            e_valid = 1'b0;
            e_last = 1'b0;
            m_in_frame = 1'b0;
            m_armed = 1'b0;
        end else if (m_in_frame) begin
            if (iReady) begin
                got.push_back(oData);
                if (m_pos >= 1 && m_pos <= DB) m_sent[m_pos-1] = oData;
                m_pos++;
                if (m_pos == DB + 2) begin
                    m_in_frame = 1'b0;
                    e_valid = 1'b0;
                    e_last = 1'b0;
                    e_done = 1'b1;
                end else if (m_pos <= DB) begin
                    e_data = m_tab[m_frame][m_pos-1];
                end else begin
                    e_data = ref_crc(m_sent);
                    e_last = 1'b1;
                end
            end
        end else if (!was_done) begin
            if (iRQ) begin
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_armed = 1'b0;
                if (int'(iNumRQ) < NF) begin
                    m_in_frame = 1'b1;
                    m_frame = int'(iNumRQ);
                    m_pos = 0;
                    e_valid = 1'b1;
                    e_data = 8'hCC;
                    e_last = 1'b0;
                    got.delete();
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        if (wr_en && int'(wr_frame) < NF && int'(wr_byte) < DB)
            m_tab[wr_frame][wr_byte] = wr_data;
    end

    logic [7:0] exp1 [11] = '{8'hCC, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                              8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rq();
        iRQ = 1'b1;
        step();
        step();
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (oDone) ok = 1'b1;
        end
        chk({nm, " done timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_byte(input string nm, input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (oValid && oData == v) ok = 1'b1;
            else step();
        end
        chk({nm, " byte timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input string nm, input logic [7:0] ex [11]);
        chk({nm, " len"}, 32'(got.size()), 32'd11);
        for (int i = 0; i < 11 && i < got.size(); i++)
            chk(nm, 32'(got[i]), 32'(ex[i]));
    endtask

    initial begin
        int cnt_v, cnt_e;
        logic [7:0] s6 [DB];
        for (int f = 0; f < NF; f++)
            for (int b = 0; b < DB; b++)
                m_tab[f][b] = 8'(f + b);

        repeat (3) step();
        chk("reset oValid", 32'(oValid), 32'd0);
        chk("reset oData", 32'(oData), 32'd0);
        chk("reset oBusy", 32'(oBusy), 32'd0);
        reset = 1'b0;

        // Load "123456789" into frame 5, plus writes that must be ignored
        for (int b = 0; b < DB; b++) begin
            wr_en = 1'b1; wr_frame = 5'd5; wr_byte = 4'(b); wr_data = 8'(8'h31 + b);
            step();
        end
        wr_frame = 5'd5; wr_byte = 4'd12; wr_data = 8'hEE; step();
        wr_frame = 5'd25; wr_byte = 4'd0; wr_data = 8'hEE; step();
        wr_en = 1'b0;
        step();

        // 1: straight frame
        iNumRQ = 5'd5; iRQ = 1'b0;
        wait_done("t1");
        check_frame("t1", exp1);
        release_rq();

        // 2: back-pressure pattern
        iNumRQ = 5'd5; iRQ = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 300 && !ok; i++) begin
                iReady = pat[i % 6];
                step();
                if (oDone) ok = 1'b1;
            end
            chk("t2 done timeout", 32'(ok), 32'd1);
        end
        iReady = 1'b1;
        check_frame("t2", exp1);

        // 3: held-low request never retriggers
        cnt_v = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (oValid) cnt_v++;
        end
        chk("t3 retrigger", 32'(cnt_v), 32'd0);
        release_rq();
        iRQ = 1'b0;
        wait_done("t3");
        check_frame("t3", exp1);
        release_rq();

        // 4: out-of-range index
        iNumRQ = 5'd25; iRQ = 1'b0;
        cnt_v = 0; cnt_e = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (oValid) cnt_v++;
            if (oErr) cnt_e++;
        end
        chk("t4 err pulses", 32'(cnt_e), 32'd1);
        chk("t4 valid", 32'(cnt_v), 32'd0);
        release_rq();
        iNumRQ = 5'd7; iRQ = 1'b0;
        wait_done("t4");
        chk("t4 len", 32'(got.size()), 32'd11);
        if (got.size() == 11) begin
            chk("t4 byte0", 32'(got[1]), 32'h07);
            chk("t4 byte8", 32'(got[9]), 32'h0F);
        end
        release_rq();

        // 5: reset mid-frame with request still low
        iNumRQ = 5'd5; iRQ = 1'b0;
        wait_byte("t5", 8'h34);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5 oValid", 32'(oValid), 32'd0);
        chk("t5 oData", 32'(oData), 32'd0);
        chk("t5 oBusy", 32'(oBusy), 32'd0);
        cnt_v = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (oValid) cnt_v++;
        end
        chk("t5 no stream", 32'(cnt_v), 32'd0);
        release_rq();
        iRQ = 1'b0;
        wait_done("t5");
        check_frame("t5", exp1);
        release_rq();

        // 6: rewrite last byte of the active default frame
        iNumRQ = 5'd0; iRQ = 1'b0;
        wait_byte("t6", 8'h02);
        wr_en = 1'b1; wr_frame = 5'd0; wr_byte = 4'd8; wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        wait_done("t6");
        chk("t6 len", 32'(got.size()), 32'd11);
        if (got.size() == 11) begin
            chk("t6 byte2", 32'(got[3]), 32'h02);
            chk("t6 byte7", 32'(got[8]), 32'h07);
            chk("t6 byte8", 32'(got[9]), 32'hAA);
            for (int i = 0; i < DB; i++) s6[i] = got[i+1];
            chk("t6 crc", 32'(got[10]), 32'(ref_crc(s6)));
        end
        release_rq();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
